// File: rtl/register8_bank.sv
// -----------------------------------------------------------------------------
// register8_bank
//   A bank of 2**ADDR_W registers, each DATA_W bits wide. It has one
//   synchronous write port and two asynchronous (combinational) read ports.
//   X0 is hardwired to zero.
//
// Ports
//   clk  in   1        rising-edge clock for all writes
//   rst  in   1        asynchronous active-low reset; 0 clears every register
//   we3  in   1        write enable; only a definite 1 writes
//   wa3  in   ADDR_W   write address (writes to 0 are dropped)
//   wd3  in   DATA_W   write data
//   ra1  in   ADDR_W   read address, port 1
//   ra2  in   ADDR_W   read address, port 2
//   rd1  out  DATA_W   X[ra1], no latency, no write bypass
//   rd2  out  DATA_W   X[ra2], no latency, no write bypass
// -----------------------------------------------------------------------------
module register8_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we3,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;

    // Entry 0 is pinned to zero here, so it never holds anything but 0.
    // Comparing against 1'b1 keeps an unknown enable from writing.
    always_comb begin
        regs_d = regs_q;
        if ((we3 == 1'b1) && (wa3 != '0)) begin
            regs_d[wa3] = wd3;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads are gated by rst so they return 0 while reset is held, even
    // in the same delta in which the asynchronous clear is taking effect.
    assign rd1 = rst ? regs_q[ra1] : '0;
    assign rd2 = rst ? regs_q[ra2] : '0;

endmodule

// File: tb/tb_register8_bank.sv
// -----------------------------------------------------------------------------
// tb_register8_bank
//   Directed test of register8_bank. Stimulus pushes the expected read data
//   into a queue and raises a sample strobe. A separate monitor pops the
//   entry on that strobe and compares it with rd1/rd2.
// -----------------------------------------------------------------------------
module tb_register8_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       we3;
    logic [2:0] wa3;
    logic [7:0] wd3;
    logic [2:0] ra1, ra2;
    logic [7:0] rd1, rd2;
    logic       smp = 1'b0;

    typedef struct {
        string      name;
        logic [7:0] e1;
        logic [7:0] e2;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    register8_bank #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .we3(we3), .wa3(wa3), .wd3(wd3),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
    );

    always #10 clk = ~clk;

    // Monitor process
    always @(posedge smp) begin
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $display("FAIL sb_underflow: strobe with empty queue");
        end else begin
            e = sb.pop_front();
            n_total++;
            if (rd1 === e.e1) n_pass++;
            else $display("FAIL %s rd1: got %02h want %02h", e.name, rd1, e.e1);
            n_total++;
            if (rd2 === e.e2) n_pass++;
            else $display("FAIL %s rd2: got %02h want %02h", e.name, rd2, e.e2);
        end
    end

    // The check task drives the read addresses, queues the expectation and
    // strobes the monitor. It takes 2 ns. When adv is set, it then moves to
    // 1 ns after the next rising edge.
    task automatic check(input string name, input logic [2:0] a1, input logic [2:0] a2,
                         input logic [7:0] e1, input logic [7:0] e2, input bit adv);
        exp_t e;
        ra1 = a1;
        ra2 = a2;
        e.name = name;
        e.e1 = e1;
        e.e2 = e2;
        sb.push_back(e);
        #1 smp = 1'b1;
        #1 smp = 1'b0;
        if (adv) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        @(posedge clk);
        #1 we3 = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        we3 = 1'b0;
        wa3 = '0;
        wd3 = '0;
        ra1 = '0;
        ra2 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        check("reset_12", 3'd1, 3'd2, 8'h00, 8'h00, 1'b1);
        check("reset_07", 3'd0, 3'd7, 8'h00, 8'h00, 1'b1);

        wr(3'd1, 8'hAA);
        wr(3'd2, 8'hBB);
        wr(3'd3, 8'hCC);
        wr(3'd4, 8'hDD);
        wr(3'd5, 8'hEE);
        wr(3'd6, 8'hFF);
        wr(3'd7, 8'h11);
        check("rd_12", 3'd1, 3'd2, 8'hAA, 8'hBB, 1'b0);
        check("rd_34", 3'd3, 3'd4, 8'hCC, 8'hDD, 1'b0);
        check("rd_56", 3'd5, 3'd6, 8'hEE, 8'hFF, 1'b0);
        check("rd_70", 3'd7, 3'd0, 8'h11, 8'h00, 1'b1);

        // Write enable is low, so nothing may change.
        we3 = 1'b0; wa3 = 3'd1; wd3 = 8'hFF;
        @(posedge clk); #1;
        check("we0_hold", 3'd1, 3'd1, 8'hAA, 8'hAA, 1'b1);

        // A write to X0 must be dropped.
        wr(3'd0, 8'h5A);
        check("x0_write", 3'd0, 3'd1, 8'h00, 8'hAA, 1'b1);

        // There is no bypass: the old value is read before the edge and
        // the new value after it.
        we3 = 1'b1; wa3 = 3'd1; wd3 = 8'h3C;
        check("pre_edge", 3'd1, 3'd1, 8'hAA, 8'hAA, 1'b0);
        @(posedge clk);
        #1 we3 = 1'b0;
        check("post_edge", 3'd1, 3'd2, 8'h3C, 8'hBB, 1'b1);

        // An unknown enable must not write.
        we3 = 1'bx; wa3 = 3'd2; wd3 = 8'h00;
        @(posedge clk);
        #1 we3 = 1'b0;
        check("we_x", 3'd2, 3'd3, 8'hBB, 8'hCC, 1'b1);

        // Assert reset asynchronously mid-cycle and hold a write through the
        // next edge. Reset wins.
        rst = 1'b0;
        we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h77;
        check("rst_01", 3'd0, 3'd1, 8'h00, 8'h00, 1'b0);
        check("rst_23", 3'd2, 3'd3, 8'h00, 8'h00, 1'b0);
        check("rst_45", 3'd4, 3'd5, 8'h00, 8'h00, 1'b0);
        check("rst_67", 3'd6, 3'd7, 8'h00, 8'h00, 1'b0);
        @(posedge clk);
        #1 we3 = 1'b0;
        rst = 1'b1;
        check("rel_01", 3'd0, 3'd1, 8'h00, 8'h00, 1'b0);
        check("rel_23", 3'd2, 3'd3, 8'h00, 8'h00, 1'b0);
        check("rel_45", 3'd4, 3'd5, 8'h00, 8'h00, 1'b0);
        check("rel_67", 3'd6, 3'd7, 8'h00, 8'h00, 1'b0);

        // The first edge after release must write normally.
        wr(3'd4, 8'h99);
        check("post_rel_wr", 3'd4, 3'd3, 8'h99, 8'h00, 1'b1);

        // Contents must persist while idle.
        repeat (5) @(posedge clk);
        #1;
        check("persist", 3'd4, 3'd4, 8'h99, 8'h99, 1'b1);

        // The queue must drain.
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL sb_drain: %0d entries left, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
